alu_acc_sequencer: RTL and testbench
====================================

// Module: alu_acc_sequencer
// PURPOSE
//  Command front end and result back end for the combinational alu_8bit. It holds an 8-bit
//  accumulator that drives the ALU A input and takes each command's operand on the B input.
//  It can repeat one opcode up to 16 times, captures Result/Carry back into the accumulator,
//  and presents a registered result with flags over a valid/ready interface.
// PARAMETERS
//  W      8   datapath width; must match alu_8bit (A/B/Result width)
//  REP_W  4   width of repeat field; an op executes cmd_rep+1 times (1..16 passes)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      block can accept a command this cycle
//  cmd_load   in   1      1: acc <= cmd_data (no ALU pass); 0: ALU op
//  cmd_op     in   3      ALU Op code (000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 NOR,110 NAND,111 XNOR)
//  cmd_data   in   W      operand B (or load value)
//  cmd_rep    in   REP_W  extra passes of same op with same B
//  alu_a      out  W      to alu_8bit.A (= acc)
//  alu_b      out  W      to alu_8bit.B (= latched operand)
//  alu_op     out  3      to alu_8bit.Op (= latched op)
//  alu_result in   W      from alu_8bit.Result
//  alu_carry  in   1      from alu_8bit.Carry
//  res_valid  out  1      result register holds an unconsumed result
//  res_ready  in   1      consumer accepts result
//  res_data   out  W      accumulator value at completion
//  res_carry  out  1      sticky OR of alu_carry over all passes of the command (0 for load)
//  res_zero   out  1      res_data == 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): acc, op/operand/counter regs, res_* = 0; state=IDLE; cmd_ready=0 during reset.
//  - FSM: IDLE -> EXEC -> DONE -> IDLE.
//    IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op, data, rep, load.
//      If load: acc<=cmd_data and go to DONE. Else: cnt<=cmd_rep, carry_acc<=0, and go to EXEC.
//    EXEC: each cycle acc<=alu_result and carry_acc|=alu_carry.
//      If cnt==0, go to DONE with res_data=new acc; else cnt<=cnt-1.
//      Each pass is 1 cycle, so an op takes rep+1 cycles.
//    DONE: res_valid=1. On res_ready, go to IDLE (res_valid drops next cycle).
//  - cmd_ready=1 only in IDLE. Commands are not accepted while a result is pending.
//  - Latency: cmd accept at edge N -> res_valid high after edge N+rep+1 (ALU op) or after N (load).
//  - res_* outputs are registered and stable while res_valid=1 && res_ready=0.
//  - ALU contract: ADD Carry = bit W of the 9-bit sum. SUB Carry = bit W of {0,A}-{0,B} (1 = borrow).
//    Logic ops Carry = 0. Arithmetic wraps modulo 2^W.
//  - Accumulator persists across commands; only load or reset changes it outside EXEC.
//  - Reset mid-EXEC or mid-DONE: the result is discarded, acc=0, and no res_valid is emitted after release.
//  - cmd_valid ignored outside IDLE; cmd_* may change freely then.
// STRUCTURE
//  - Shared package: opcode localparams (OP_ADD..OP_XNOR), state encoding (IDLE/EXEC/DONE), W default.
//  - Top instantiates nothing internally; alu_8bit is connected at the parent level via alu_* ports.
//  - One natural sub-module: alu_acc_fsm (state, repeat counter, cmd_ready/res_valid generation).
// TESTING (bench instantiates alu_8bit + alu_acc_sequencer)
//  - Load 0x0F, then ADD 0x01 rep0 -> res_data=0x10, carry=0, zero=0, valid 1 cycle after accept.
//  - Load 0xF0, then ADD 0x10 rep0 -> res_data=0x00, carry=1, zero=1.
//  - Load 0x00, then ADD 0x05 rep3 -> 4 EXEC cycles, res_data=0x14, carry=0.
//  - Load 0x55, then SUB 0xAA rep0 -> res_data=0xAB, carry=1. Then AND 0x0F -> 0x0B, carry=0.
//  - Hold res_ready=0 for 5 cycles -> res_* stable, cmd_ready=0, extra cmd_valid ignored.
//  - Assert rst_n=0 during ADD rep7 at pass 3 -> all outputs 0 immediately; no result after release.

Source files
------------

// File: rtl/alu_acc_sequencer_pkg.sv
// Shared definitions for the accumulator sequencer and its companion alu_8bit:
// opcode values, FSM state encoding and default widths.
package alu_acc_sequencer_pkg;

    localparam int W_DEF     = 8;
    localparam int REP_W_DEF = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Everything except ADD/SUB is bitwise and never produces a carry.
    function automatic logic is_logic_op(input logic [2:0] op);
        return op[2] | op[1];
    endfunction

endpackage

// File: rtl/alu_acc_sequencer_if.sv
// Command and result handshake bundle. The sequencer sits on the slave side,
// the command producer / result consumer on the master side.
interface alu_acc_sequencer_if #(
    parameter int W     = 8,
    parameter int REP_W = 4
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [2:0]       cmd_op;
    logic [W-1:0]     cmd_data;
    logic [REP_W-1:0] cmd_rep;

    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic             res_carry;
    logic             res_zero;

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_data, cmd_rep, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_data, cmd_rep, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero
    );

endinterface

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU driven by the sequencer. Carry is bit 8 of the
// zero-extended sum/difference (borrow for SUB) and 0 for bitwise ops.
module alu_8bit
    import alu_acc_sequencer_pkg::*;
(
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] Op,
    output logic [7:0] Result,
    output logic       Carry
);

    logic [8:0] wide;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        wide = '0;
        case (Op)
            OP_ADD:  wide = {1'b0, A} + {1'b0, B};
            OP_SUB:  wide = {1'b0, A} - {1'b0, B};
            OP_AND:  wide = {1'b0, A & B};
            OP_OR:   wide = {1'b0, A | B};
            OP_XOR:  wide = {1'b0, A ^ B};
            OP_NOR:  wide = {1'b0, ~(A | B)};
            OP_NAND: wide = {1'b0, ~(A & B)};
            default: wide = {1'b0, ~(A ^ B)};
        endcase
        Result = wide[7:0];
        Carry  = wide[8] & ~is_logic_op(Op);
    end

endmodule

// File: rtl/alu_acc_fsm.sv
// Control for the sequencer: IDLE -> EXEC -> DONE -> IDLE, the repeat
// counter, and the cmd_ready / res_valid handshake outputs.
module alu_acc_fsm
    import alu_acc_sequencer_pkg::*;
#(
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic             cmd_load,
    input  logic [REP_W-1:0] cmd_rep,
    input  logic             res_ready,
    output logic             cmd_ready,
    output logic             cmd_accept,
    output logic             exec_pass,
    output logic             exec_last,
    output logic             res_valid
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [REP_W-1:0] cnt;

    // Gating with rst_n keeps the block from advertising readiness while held in reset.
    assign cmd_ready  = rst_n && (state == ST_IDLE);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign exec_pass  = (state == ST_EXEC);
    assign exec_last  = exec_pass && (cnt == '0);
    assign res_valid  = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_accept) state_nxt = cmd_load ? ST_DONE : ST_EXEC;
            ST_EXEC: if (cnt == '0)  state_nxt = ST_DONE;
            ST_DONE: if (res_ready)  state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_accept) begin
                cnt <= cmd_rep;
            end else if (exec_pass && (cnt != '0)) begin
                cnt <= cnt - REP_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_acc_sequencer.sv
// Accumulator front/back end for an external alu_8bit: feeds acc/operand/op to
// the ALU, folds results back into acc and presents a registered result.
module alu_acc_sequencer
    import alu_acc_sequencer_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_acc_sequencer_if.slave   bus,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    output logic [2:0]           alu_op,
    input  logic [W-1:0]         alu_result,
    input  logic                 alu_carry
);

    logic         cmd_accept;
    logic         exec_pass;
    logic         exec_last;

    logic [W-1:0] acc;
    logic [W-1:0] operand;
    logic [2:0]   op_q;
    logic         carry_acc;
    logic [W-1:0] res_data_q;
    logic         res_carry_q;
    logic         res_zero_q;

    alu_acc_fsm #(.REP_W(REP_W)) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (bus.cmd_valid),
        .cmd_load   (bus.cmd_load),
        .cmd_rep    (bus.cmd_rep),
        .res_ready  (bus.res_ready),
        .cmd_ready  (bus.cmd_ready),
        .cmd_accept (cmd_accept),
        .exec_pass  (exec_pass),
        .exec_last  (exec_last),
        .res_valid  (bus.res_valid)
    );

    assign alu_a  = acc;
    assign alu_b  = operand;
    assign alu_op = op_q;

    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_zero  = res_zero_q;

    // Result registers only move on load accept or the final pass, so they hold steady in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            operand     <= '0;
            op_q        <= OP_ADD;
            carry_acc   <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            if (cmd_accept) begin
                op_q    <= bus.cmd_op;
                operand <= bus.cmd_data;
                if (bus.cmd_load) begin
                    acc         <= bus.cmd_data;
                    res_data_q  <= bus.cmd_data;
                    res_carry_q <= 1'b0;
                    res_zero_q  <= (bus.cmd_data == '0);
                end else begin
                    carry_acc <= 1'b0;
                end
            end

            if (exec_pass) begin
                acc       <= alu_result;
                carry_acc <= carry_acc | alu_carry;
                if (exec_last) begin
                    res_data_q  <= alu_result;
                    res_carry_q <= carry_acc | alu_carry;
                    res_zero_q  <= (alu_result == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Randomized and directed bench for alu_acc_sequencer paired with alu_8bit,
// checked against an arithmetic model of the accumulator.
module tb_alu_acc_sequencer;
    import alu_acc_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_carry;

    int errors = 0;
    int checks = 0;
    int m_acc  = 0;

    alu_acc_sequencer_if #(.W(8), .REP_W(4)) bus ();

    alu_acc_sequencer #(.W(8), .REP_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_carry  (alu_carry)
    );

    alu_8bit u_alu (
        .A      (alu_a),
        .B      (alu_b),
        .Op     (alu_op),
        .Result (alu_result),
        .Carry  (alu_carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // One ALU pass from the opcode table: 8-bit wrap, carry/borrow out of bit 8.
    function automatic int model_pass(input int a, input int b, input int op, output int c);
        int r;
        c = 0;
        case (op)
            0: begin r = a + b; c = (r > 255) ? 1 : 0; end
            1: begin r = a - b; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~(a | b);
            6: r = ~(a & b);
            default: r = ~(a ^ b);
        endcase
        return r & 255;
    endfunction

    task automatic run_cmd(input int ld, input int op, input int data, input int rep, input int hold);
        int exp_c, c, t, lat;
        exp_c = 0;
        if (ld != 0) begin
            m_acc = data;
        end else begin
            for (int p = 0; p <= rep; p++) begin
                m_acc = model_pass(m_acc, data, op, c);
                exp_c = exp_c | c;
            end
        end

        @(negedge clk);
        t = 0;
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ready_wait", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = ld[0];
        bus.cmd_op    = op[2:0];
        bus.cmd_data  = data[7:0];
        bus.cmd_rep   = rep[3:0];
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;

        lat = 0;
        while (!bus.res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, (ld != 0) ? 0 : rep + 1);
        check("res_data", int'(bus.res_data), m_acc);
        check("res_carry", int'(bus.res_carry), exp_c);
        check("res_zero", int'(bus.res_zero), (m_acc == 0) ? 1 : 0);
        check("busy_cmd_ready", int'(bus.cmd_ready), 0);
        check("acc_drive", int'(alu_a), m_acc);

        // Stall the consumer and try to sneak a load command in.
        repeat (hold) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_load  = 1'b1;
            bus.cmd_data  = 8'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", int'(bus.res_valid), 1);
            check("hold_data", int'(bus.res_data), m_acc);
            check("hold_carry", int'(bus.res_carry), exp_c);
            check("hold_cmd_ready", int'(bus.cmd_ready), 0);
        end

        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check("valid_drop", int'(bus.res_valid), 0);
        check("acc_persist", int'(alu_a), m_acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_valid;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 8'd0;
        bus.cmd_rep   = 4'd0;
        bus.res_ready = 1'b0;

        #3;
        check("rst_cmd_ready", int'(bus.cmd_ready), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_alu_a", int'(alu_a), 0);
        check("rst_res_data", int'(bus.res_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        run_cmd(1, 0, 'h0F, 0, 0);
        run_cmd(0, int'(OP_ADD), 'h01, 0, 0);
        run_cmd(1, 0, 'hF0, 0, 0);
        run_cmd(0, int'(OP_ADD), 'h10, 0, 0);
        run_cmd(1, 0, 'h00, 0, 0);
        run_cmd(0, int'(OP_ADD), 'h05, 3, 0);
        run_cmd(1, 0, 'h55, 0, 0);
        run_cmd(0, int'(OP_SUB), 'hAA, 0, 0);
        run_cmd(0, int'(OP_AND), 'h0F, 0, 5);

        // Reset during pass 3 of an ADD rep7
        run_cmd(1, 0, 'h01, 0, 0);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b0;
        bus.cmd_op    = OP_ADD;
        bus.cmd_data  = 8'h01;
        bus.cmd_rep   = 4'd7;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_acc = 0;
        check("mid_rst_alu_a", int'(alu_a), 0);
        check("mid_rst_alu_b", int'(alu_b), 0);
        check("mid_rst_alu_op", int'(alu_op), 0);
        check("mid_rst_res_valid", int'(bus.res_valid), 0);
        check("mid_rst_res_data", int'(bus.res_data), 0);
        check("mid_rst_res_carry", int'(bus.res_carry), 0);
        check("mid_rst_cmd_ready", int'(bus.cmd_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) seen_valid = 1'b1;
        end
        check("no_result_after_rst", int'(seen_valid), 0);
        check("post_rst_cmd_ready", int'(bus.cmd_ready), 1);
        check("post_rst_acc", int'(alu_a), 0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            int ld, op, data, rep, hold;
            ld   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            op   = int'($urandom_range(0, 7));
            data = int'($urandom_range(0, 255));
            rep  = int'($urandom_range(0, 15));
            hold = int'($urandom_range(0, 3));
            run_cmd(ld, op, data, rep, hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
